debounce_bank: RTL and testbench

//   Parametrised multi-channel debouncer; successor to the single-channel debouncer.
//   Per channel: 2-FF input synchroniser, bounce filter, one-cycle press/release pulses.

---
 rtl/debounce_bank.sv | 106 ++++++++++
 tb/tb_debounce_bank.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer: 2-FF synchroniser, bounce filter, press/release
// pulses, and a long-press pulse with optional auto-repeat, each gated by a channel enable.
module debounce_bank #(
    parameter int CHANNELS   = 4,
    parameter int COUNT_MAX  = 500000,
    parameter int HOLD_MAX   = 50000000,
    parameter int REPEAT_MAX = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    localparam int CW       = $clog2(COUNT_MAX + 1);
    localparam int HOLD_TOP = (HOLD_MAX > REPEAT_MAX) ? HOLD_MAX : REPEAT_MAX;
    localparam int HW       = $clog2(HOLD_TOP + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(COUNT_MAX - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_MAX > 0) ? REPEAT_MAX - 1 : 0);

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;

    // The synchroniser ignores en so a re-enabled channel sees the current level at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            // NOTE: non-blocking assignments make s2 take the old s1, giving a true 2-FF chain.
            s1 <= button_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [HW-1:0] hold;
        logic          bo;
        logic          repeating;
        logic          spent;
        logic          accept;
        logic          rise;
        logic          fall;
        logic          hold_due;

        assign accept   = (s2[i] != bo) && (cnt == CNT_LAST);
        assign rise     = accept && !bo;
        assign fall     = accept && bo;
        assign hold_due = repeating ? (hold == REP_LAST) : (hold == HOLD_LAST);

        always_ff @(posedge clk) begin
            if (!reset || !en[i]) begin
                cnt              <= '0;
                hold             <= '0;
                bo               <= 1'b0;
                repeating        <= 1'b0;
                spent            <= 1'b0;
                press_pulse[i]   <= 1'b0;
                release_pulse[i] <= 1'b0;
                long_pulse[i]    <= 1'b0;
            end else begin
                press_pulse[i]   <= rise;
                release_pulse[i] <= fall;
                long_pulse[i]    <= 1'b0;

                if (s2[i] == bo) begin
                    cnt <= '0;
                end else if (accept) begin
                    cnt <= '0;
                    bo  <= s2[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end

                // A release on the edge a long pulse is due suppresses that pulse.
                if (accept) begin
                    hold      <= '0;
                    repeating <= 1'b0;
                    spent     <= 1'b0;
                end else if (bo && !spent) begin
                    if (hold_due) begin
                        long_pulse[i] <= 1'b1;
                        hold          <= '0;
                        if (REPEAT_MAX > 0) begin
                            repeating <= 1'b1;
                        end else begin
                            spent <= 1'b1;
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
            end
        end

        assign button_out[i] = bo;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: a window-based reference model checked every
// cycle, plus directed scenarios with literal expectations at the key edges.
module tb_debounce_bank;

    localparam int CH = 2;
    localparam int CM = 8;
    localparam int HM = 20;
    localparam int RM = 5;
    localparam int HIST = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] en;
    logic [CH-1:0] button_in;
    logic [CH-1:0] button_out;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] long_pulse;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    debounce_bank #(
        .CHANNELS(CH), .COUNT_MAX(CM), .HOLD_MAX(HM), .REPEAT_MAX(RM)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .button_in(button_in),
        .button_out(button_out), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: debounced level flips once the last COUNT_MAX samples seen since
    // enable all disagree with it; long pulses follow from time elapsed since the press.
    bit [CH-1:0] m_s1, m_s2, m_bo, m_pr, m_rl, m_lg;
    bit          hist [CH][HIST];
    int          n_en [CH];
    int          press_t [CH];
    int          t = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_bo = '0; m_pr = '0; m_rl = '0; m_lg = '0;
            for (int c = 0; c < CH; c++) begin
                n_en[c] = 0;
                press_t[c] = -1;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_pr[c] = 0; m_rl[c] = 0; m_lg[c] = 0;
                if (!en[c]) begin
                    m_bo[c] = 0;
                    n_en[c] = 0;
                    press_t[c] = -1;
                end else begin
                    bit flip;
                    int d;
                    hist[c][n_en[c]] = m_s2[c];
                    n_en[c]++;
                    flip = (n_en[c] >= CM);
                    for (int j = n_en[c] - CM; j < n_en[c] && j >= 0; j++)
                        if (hist[c][j] == m_bo[c]) flip = 0;
                    if (flip) begin
                        m_bo[c] = m_s2[c];
                        if (m_bo[c]) begin
                            m_pr[c] = 1;
                            press_t[c] = t;
                        end else begin
                            m_rl[c] = 1;
                            press_t[c] = -1;
                        end
                    end else if (m_bo[c]) begin
                        d = t - press_t[c];
                        if (d == HM || (RM > 0 && d > HM && (d - HM) % RM == 0))
                            m_lg[c] = 1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = button_in;
            t++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model button_out", {30'd0, button_out}, {30'd0, m_bo});
            check("model press_pulse", {30'd0, press_pulse}, {30'd0, m_pr});
            check("model release_pulse", {30'd0, release_pulse}, {30'd0, m_rl});
            check("model long_pulse", {30'd0, long_pulse}, {30'd0, m_lg});
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        started = 1;
    endtask

    initial begin
        reset = 1'b0;
        en = 2'b11;
        button_in = 2'b11;

        // 1: held buttons through reset, then a fresh press on edge 10
        for (int k = 0; k < 3; k++) begin
            step();
            check("reset outputs", {button_out, press_pulse, release_pulse, long_pulse}, 8'h00);
        end
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9) check("t1 out before edge 10", {30'd0, button_out}, 32'd0);
        end
        check("t1 button_out edge 10", {30'd0, button_out}, 32'd3);
        check("t1 press_pulse edge 10", {30'd0, press_pulse}, 32'd3);
        step();
        check("t1 press_pulse edge 11", {30'd0, press_pulse}, 32'd0);
        button_in = 2'b00;
        for (int k = 0; k < 25; k++) step();
        check("t1 released", {30'd0, button_out}, 32'd0);

        // 2: ch0 bounces every 3 edges, then settles high
        for (int k = 0; k < 10; k++) begin
            button_in[0] = (k % 2 == 0);
            for (int j = 0; j < 3; j++) step();
        end
        check("t2 no accept while bouncing", {31'd0, button_out[0]}, 32'd0);
        button_in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        check("t2 button_out after settle", {31'd0, button_out[0]}, 32'd1);
        check("t2 press_pulse after settle", {31'd0, press_pulse[0]}, 32'd1);

        // 3: long press with auto-repeat, then release
        for (int d = 1; d <= 39; d++) begin
            step();
            check("t3 long_pulse", {31'd0, long_pulse[0]},
                  (d == 20 || d == 25 || d == 30 || d == 35) ? 32'd1 : 32'd0);
        end
        button_in[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t3 release_pulse", {31'd0, release_pulse[0]}, (k == 10) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            check("t3 no long after release", {31'd0, long_pulse[0]}, 32'd0);
        end

        // 4: clean press on ch0 while ch1 bounces every 2 edges
        button_in[0] = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            button_in[1] = (((s - 1) / 2) % 2 == 0);
            step();
            check("t4 ch1 quiet", {29'd0, button_out[1], press_pulse[1], long_pulse[1]}, 32'd0);
        end
        check("t4 ch0 press edge 10", {31'd0, press_pulse[0]}, 32'd1);
        button_in[1] = 1'b0;

        // 5: disable while held, then re-enable
        for (int d = 1; d <= 11; d++) step();
        en[0] = 1'b0;
        step();
        check("t5 disabled button_out", {31'd0, button_out[0]}, 32'd0);
        check("t5 no release on disable", {31'd0, release_pulse[0]}, 32'd0);
        for (int k = 0; k < 3; k++) step();
        en[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("t5 press on 8th enabled edge", {31'd0, press_pulse[0]}, (k == 8) ? 32'd1 : 32'd0);
        end

        // 6: release lands on the same edge the first long pulse is due
        for (int d = 1; d <= 10; d++) step();
        button_in[0] = 1'b0;
        for (int d = 11; d <= 20; d++) begin
            step();
            check("t6 release_pulse", {31'd0, release_pulse[0]}, (d == 20) ? 32'd1 : 32'd0);
        end
        check("t6 release beats long", {31'd0, long_pulse[0]}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            check("t6 no late long", {31'd0, long_pulse[0]}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
